// File: rtl/dps_uart_rx_core.sv
// dps_uart_rx_core: UART receive engine (8N1, LSB first).
// Synchronizes the serial line, filters it with a 3-sample majority vote,
// samples each bit at mid-bit and checks the stop bit. Good bytes produce a
// one-cycle valid strobe. A low stop bit produces a one-cycle frame-error strobe.
module dps_uart_rx_core #(
    parameter logic        P_EXTBAUD    = 1'b1,
    parameter logic [19:0] P_BAUD_COUNT = 20'd108
) (
    input  logic        iCLOCK,
    input  logic        iRESET,
    input  logic        iRX_EN,
    input  logic [19:0] iBAUD_COUNT,
    output logic        oRX_VALID,
    output logic [7:0]  oRX_DATA,
    output logic        oFRAME_ERR,
    output logic        oRX_BUSY,
    input  logic        iUART_RXD
);

    typedef enum logic [2:0] {
        stIdle,
        stStart,
        stData,
        stStop,
        stBreak
    } rxState_t;

    rxState_t    state;
    rxState_t    stateNext;

    logic [1:0]  rxSync;
    logic [2:0]  hist;
    logic        majority;

    logic [19:0] baudSel;
    logic [19:0] nSel;
    logic [19:0] nLat;
    logic [19:0] nHalf;
    logic [19:0] nLast;
    logic [19:0] cnt;
    logic [3:0]  bitCnt;
    logic [7:0]  shReg;

    logic        cntClr;
    logic        latchN;
    logic        bitClr;
    logic        shiftEn;
    logic        validSet;
    logic        ferrSet;

    assign baudSel  = P_EXTBAUD ? iBAUD_COUNT : P_BAUD_COUNT;
    assign nSel     = (baudSel < 20'd4) ? 20'd4 : baudSel;
    assign nHalf    = nLat >> 1;
    assign nLast    = nLat - 20'd1;
    assign majority = (hist[2] & hist[1]) | (hist[2] & hist[0]) | (hist[1] & hist[0]);

    // Two-flop synchronizer followed by a 3-sample history (hist[0] newest)
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            rxSync <= '1;
            hist   <= '1;
        end else begin
            rxSync <= {rxSync[0], iUART_RXD};
            hist   <= {hist[1:0], rxSync[1]};
        end
    end

    // State register
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            state <= stIdle;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic and datapath control strobes
    always_comb begin
        stateNext = state;
        cntClr    = 1'b0;
        latchN    = 1'b0;
        bitClr    = 1'b0;
        shiftEn   = 1'b0;
        validSet  = 1'b0;
        ferrSet   = 1'b0;
        if (!iRX_EN) begin
            stateNext = stIdle;
            cntClr    = 1'b1;
            bitClr    = 1'b1;
        end else begin
            case (state)
                stIdle: begin
                    cntClr = 1'b1;
                    if (hist[1] && !hist[0]) begin
                        stateNext = stStart;
                        latchN    = 1'b1;
                    end
                end
                stStart: begin
                    if (cnt == nHalf) begin
                        cntClr = 1'b1;
                        if (majority) begin
                            stateNext = stIdle;
                        end else begin
                            stateNext = stData;
                            bitClr    = 1'b1;
                        end
                    end
                end
                stData: begin
                    if (cnt == nLast) begin
                        cntClr  = 1'b1;
                        shiftEn = 1'b1;
                        if (bitCnt == 4'd7) begin
                            stateNext = stStop;
                        end
                    end
                end
                stStop: begin
                    if (cnt == nLast) begin
                        cntClr = 1'b1;
                        if (majority) begin
                            validSet  = 1'b1;
                            stateNext = stIdle;
                        end else begin
                            ferrSet   = 1'b1;
                            stateNext = stBreak;
                        end
                    end
                end
                stBreak: begin
                    cntClr = 1'b1;
                    if (majority) begin
                        stateNext = stIdle;
                    end
                end
                default: begin
                    stateNext = stIdle;
                    cntClr    = 1'b1;
                end
            endcase
            if (stateNext != state) begin
                cntClr = 1'b1;
            end
        end
    end

    // Counters, shift register, baud latch and registered outputs
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            cnt        <= '0;
            nLat       <= '0;
            bitCnt     <= '0;
            shReg      <= '0;
            oRX_VALID  <= 1'b0;
            oRX_DATA   <= '0;
            oFRAME_ERR <= 1'b0;
            oRX_BUSY   <= 1'b0;
        end else begin
            cnt <= cntClr ? '0 : cnt + 20'd1;
            if (latchN) begin
                nLat <= nSel;
            end
            if (bitClr) begin
                bitCnt <= '0;
            end else if (shiftEn) begin
                bitCnt <= bitCnt + 4'd1;
            end
            if (shiftEn) begin
                shReg <= {majority, shReg[7:1]};
            end
            if (validSet) begin
                oRX_DATA <= shReg;
            end
            oRX_VALID  <= validSet;
            oFRAME_ERR <= ferrSet;
            oRX_BUSY   <= (stateNext != stIdle);
        end
    end

endmodule

// File: tb/tb_dps_uart_rx_core.sv
// Directed bench for dps_uart_rx_core with a byte scoreboard per instance.
module tb_dps_uart_rx_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic [19:0] baud = 20'd16;
    logic        rxdA = 1'b1;
    logic        rxdB = 1'b1;

    logic        validA, ferrA, busyA;
    logic [7:0]  dataA;
    logic        validB, ferrB, busyB;
    logic [7:0]  dataB;

    int unsigned assertCount = 0;
    int unsigned failCount   = 0;
    int unsigned cyc         = 0;
    int unsigned validCntA   = 0;
    int unsigned ferrCntA    = 0;
    int unsigned validCntB   = 0;
    int unsigned lastValidCycA = 0;
    int unsigned startCycA   = 0;

    logic [7:0] qA[$];
    logic [7:0] qB[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    dps_uart_rx_core dut (
        .iCLOCK      (clk),
        .iRESET      (rst),
        .iRX_EN      (en),
        .iBAUD_COUNT (baud),
        .oRX_VALID   (validA),
        .oRX_DATA    (dataA),
        .oFRAME_ERR  (ferrA),
        .oRX_BUSY    (busyA),
        .iUART_RXD   (rxdA)
    );

    dps_uart_rx_core #(
        .P_EXTBAUD    (1'b0),
        .P_BAUD_COUNT (20'd108)
    ) dutFix (
        .iCLOCK      (clk),
        .iRESET      (rst),
        .iRX_EN      (en),
        .iBAUD_COUNT (baud),
        .oRX_VALID   (validB),
        .oRX_DATA    (dataB),
        .oFRAME_ERR  (ferrB),
        .oRX_BUSY    (busyB),
        .iUART_RXD   (rxdB)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every valid strobe
    always @(negedge clk) begin
        if (!rst) begin
            if (validA || ferrA) begin
                check("strobeExclusiveA", {31'd0, validA & ferrA}, 32'd0);
            end
            if (validA) begin
                validCntA++;
                lastValidCycA = cyc;
                if (qA.size() == 0) begin
                    check("unexpectedValidA", {24'd0, dataA}, 32'hFFFF_FFFF);
                end else begin
                    check("dataA", {24'd0, dataA}, {24'd0, qA.pop_front()});
                end
            end
            if (ferrA) ferrCntA++;
            if (validB) begin
                validCntB++;
                if (qB.size() == 0) begin
                    check("unexpectedValidB", {24'd0, dataB}, 32'hFFFF_FFFF);
                end else begin
                    check("dataB", {24'd0, dataB}, {24'd0, qB.pop_front()});
                end
            end
            if (ferrB) begin
                check("unexpectedFerrB", 32'd1, 32'd0);
            end
        end
    end

    task automatic hold(input bit toFixed, input logic v, input int unsigned n);
        if (toFixed) rxdB = v;
        else         rxdA = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic sendFrame(input bit toFixed, input logic [7:0] d, input logic stopBit,
                             input int unsigned bitClk);
        if (!toFixed) startCycA = cyc;
        hold(toFixed, 1'b0, bitClk);
        for (int i = 0; i < 8; i++) hold(toFixed, d[i], bitClk);
        hold(toFixed, stopBit, bitClk);
    endtask

    task automatic drain(input string tag, input int unsigned budget);
        for (int unsigned i = 0; i < budget; i++) begin
            if (qA.size() == 0 && qB.size() == 0) break;
            @(negedge clk);
        end
        check(tag, qA.size() + qB.size(), 32'd0);
    endtask

    int unsigned vBase;
    int unsigned fBase;
    int          lat;

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rstValid", {31'd0, validA}, 32'd0);
        check("rstData",  {24'd0, dataA},  32'd0);
        check("rstFerr",  {31'd0, ferrA},  32'd0);
        check("rstBusy",  {31'd0, busyA},  32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Basic byte and latency
        baud = 20'd16;
        qA.push_back(8'h55);
        sendFrame(1'b0, 8'h55, 1'b1, 16);
        hold(1'b0, 1'b1, 32);
        drain("drainBasic", 200);
        lat = int'(lastValidCycA) - int'(startCycA) - 156;
        check("latencyWindow", {31'd0, (lat >= -2 && lat <= 2)}, 32'd1);
        check("basicValidCnt", validCntA, 32'd1);
        check("basicFerr", ferrCntA, 32'd0);
        check("basicBusyIdle", {31'd0, busyA}, 32'd0);

        // Back-to-back frames
        vBase = validCntA;
        qA.push_back(8'h00); qA.push_back(8'hFF); qA.push_back(8'hA3);
        sendFrame(1'b0, 8'h00, 1'b1, 16);
        sendFrame(1'b0, 8'hFF, 1'b1, 16);
        sendFrame(1'b0, 8'hA3, 1'b1, 16);
        hold(1'b0, 1'b1, 32);
        drain("drainB2B", 200);
        check("b2bValidCnt", validCntA - vBase, 32'd3);

        // Framing error: stop low, line held low 40 clocks, then high
        vBase = validCntA;
        fBase = ferrCntA;
        hold(1'b0, 1'b0, 16);
        for (int i = 0; i < 8; i++) hold(1'b0, (8'hA3 >> i) & 8'h01, 16);
        hold(1'b0, 1'b0, 40);
        hold(1'b0, 1'b1, 32);
        check("ferrCount", ferrCntA - fBase, 32'd1);
        check("ferrNoValid", validCntA - vBase, 32'd0);
        check("ferrDataHeld", {24'd0, dataA}, 32'hA3);
        qA.push_back(8'h3C);
        sendFrame(1'b0, 8'h3C, 1'b1, 16);
        hold(1'b0, 1'b1, 32);
        drain("drainAfterFerr", 200);
        check("dataAfterFerr", {24'd0, dataA}, 32'h3C);

        // Noise: 3-clock glitch on idle line
        vBase = validCntA;
        fBase = ferrCntA;
        hold(1'b0, 1'b0, 3);
        hold(1'b0, 1'b1, 40);
        check("glitchBusy", {31'd0, busyA}, 32'd0);
        check("glitchNoStrobe", (validCntA - vBase) + (ferrCntA - fBase), 32'd0);

        // Noise: 1-clock high spike inside data bit 3 of 0x00
        qA.push_back(8'h00);
        hold(1'b0, 1'b0, 16);
        hold(1'b0, 1'b0, 48);
        hold(1'b0, 1'b0, 9);
        hold(1'b0, 1'b1, 1);
        hold(1'b0, 1'b0, 6);
        hold(1'b0, 1'b0, 64);
        hold(1'b0, 1'b1, 16);
        hold(1'b0, 1'b1, 32);
        drain("drainSpike", 200);
        check("spikeData", {24'd0, dataA}, 32'h00);

        // Clamp: programmed 2 behaves as 4 clocks per bit
        baud = 20'd2;
        qA.push_back(8'h96);
        sendFrame(1'b0, 8'h96, 1'b1, 4);
        hold(1'b0, 1'b1, 16);
        drain("drainClamp", 100);
        check("clampData", {24'd0, dataA}, 32'h96);

        // Fixed-rate instance ignores iBAUD_COUNT
        baud = 20'd16;
        qB.push_back(8'h5A);
        sendFrame(1'b1, 8'h5A, 1'b1, 108);
        hold(1'b1, 1'b1, 64);
        drain("drainFixed", 400);
        check("fixedValidCnt", validCntB, 32'd1);
        check("fixedData", {24'd0, dataB}, 32'h5A);

        // Reset during data bit 4
        hold(1'b0, 1'b0, 16);
        for (int i = 0; i < 4; i++) hold(1'b0, 1'b1, 16);
        hold(1'b0, 1'b0, 8);
        check("busyBeforeReset", {31'd0, busyA}, 32'd1);
        rst = 1'b1;
        rxdA = 1'b1;
        #1;
        check("midRstValid", {31'd0, validA}, 32'd0);
        check("midRstData",  {24'd0, dataA},  32'd0);
        check("midRstFerr",  {31'd0, ferrA},  32'd0);
        check("midRstBusy",  {31'd0, busyA},  32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        hold(1'b0, 1'b1, 8);
        qA.push_back(8'h81);
        sendFrame(1'b0, 8'h81, 1'b1, 16);
        hold(1'b0, 1'b1, 32);
        drain("drainAfterRst", 200);
        check("dataAfterRst", {24'd0, dataA}, 32'h81);

        // Disable during data
        vBase = validCntA;
        fBase = ferrCntA;
        hold(1'b0, 1'b0, 16);
        hold(1'b0, 1'b1, 16);
        hold(1'b0, 1'b0, 16);
        hold(1'b0, 1'b1, 8);
        check("busyBeforeDisable", {31'd0, busyA}, 32'd1);
        en = 1'b0;
        @(negedge clk);
        check("busyAfterDisable", {31'd0, busyA}, 32'd0);
        hold(1'b0, 1'b1, 7);
        for (int i = 0; i < 4; i++) hold(1'b0, 1'b0, 16);
        hold(1'b0, 1'b1, 32);
        en = 1'b1;
        hold(1'b0, 1'b1, 40);
        check("disableNoStrobe", (validCntA - vBase) + (ferrCntA - fBase), 32'd0);
        check("disableDataHeld", {24'd0, dataA}, 32'h81);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
